sram22_port_ctrl: RTL and testbench

Single-port request/response controller that drives an sram22 SRAM macro (`we`/`wmask`/`addr`/`din` in, `dout` out one cycle later) from a valid/ready request stream. It returns read data through a buffered valid/ready response stream. It sits between bus/accelerator logic and each sram22 macro instance. It absorbs the macro's fixed read latency and lets the response consumer stall without losing data.

---
 rtl/sram22_port_ctrl.sv | 140 ++++++++++++++
 tb/tb_sram22_port_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram22_port_ctrl.sv
// sram22_port_ctrl
//   Drives one sram22 macro (we/wmask/addr/din, dout one cycle later) from a
//   valid/ready request stream and returns read data through a buffered
//   valid/ready response stream. Credit-based: a request is only accepted when
//   the response FIFO can hold every beat already buffered or in flight. As a
//   result, the FIFO can never overflow, and rsp_ready never reaches req_ready
//   combinationally.
//
// Optional feature (compile-time macro):
//   SRAM22_CTRL_WRITE_ACK_EN - every accepted write also consumes a credit and
//   returns a beat with rsp_rdata = 0, kept in order with read beats.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   req_*            request stream (valid/ready, we, wmask, addr, wdata)
//   rsp_*            response stream (valid/ready, rdata)
//   sram_we/wmask/addr/din  macro inputs (combinational from the request)
//   sram_dout        macro read data, valid the cycle after a read is issued
module sram22_port_ctrl #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 6,
    parameter int unsigned WMASK_WIDTH = 1,
    parameter int unsigned FIFO_DEPTH  = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [WMASK_WIDTH-1:0] req_wmask,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic [DATA_WIDTH-1:0]  req_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_WIDTH-1:0]  rsp_rdata,
    output logic                   sram_we,
    output logic [WMASK_WIDTH-1:0] sram_wmask,
    output logic [ADDR_WIDTH-1:0]  sram_addr,
    output logic [DATA_WIDTH-1:0]  sram_din,
    input  logic [DATA_WIDTH-1:0]  sram_dout
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    // One extra bit so count + pending never wraps.
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1) + 1;

    typedef logic [PtrW-1:0] ptr_t;
    typedef logic [CntW-1:0] cnt_t;

    localparam ptr_t LastPtr  = ptr_t'(FIFO_DEPTH - 1);
    localparam cnt_t DepthCnt = cnt_t'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] fifo_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_d [FIFO_DEPTH];
    ptr_t                  wr_ptr_q, wr_ptr_d;
    ptr_t                  rd_ptr_q, rd_ptr_d;
    cnt_t                  count_q, count_d;
    logic                  pending_q, pending_d;
    logic                  accept, push, pop;
    logic [DATA_WIDTH-1:0] push_data;
`ifdef SRAM22_CTRL_WRITE_ACK_EN
    // Marks that the in-flight beat is a write ack rather than macro data.
    logic                  ack_q, ack_d;
`endif

    // Credit check uses registered state only.
    assign req_ready = !rst && ((count_q + cnt_t'(pending_q)) < DepthCnt);
    assign accept    = req_valid && req_ready;

    assign sram_we    = accept && req_we;
    assign sram_wmask = req_wmask;
    assign sram_addr  = req_addr;
    assign sram_din   = req_wdata;

    assign rsp_valid = (count_q != '0);
    assign rsp_rdata = fifo_q[rd_ptr_q];

    always_comb begin
        push = pending_q;
        pop  = rsp_valid && rsp_ready;

`ifdef SRAM22_CTRL_WRITE_ACK_EN
        pending_d = accept;
        ack_d     = accept && req_we;
        push_data = ack_q ? '0 : sram_dout;
`else
        pending_d = accept && !req_we;
        push_data = sram_dout;
`endif

        fifo_d = fifo_q;
        if (push) begin
            fifo_d[wr_ptr_q] = push_data;
        end

        wr_ptr_d = wr_ptr_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + ptr_t'(1);
        end

        rd_ptr_d = rd_ptr_q;
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + ptr_t'(1);
        end

        count_d = count_q + cnt_t'(push) - cnt_t'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            pending_q <= 1'b0;
`ifdef SRAM22_CTRL_WRITE_ACK_EN
            ack_q     <= 1'b0;
`endif
        end else begin
            fifo_q    <= fifo_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            pending_q <= pending_d;
`ifdef SRAM22_CTRL_WRITE_ACK_EN
            ack_q     <= ack_d;
`endif
        end
    end

`ifndef SYNTHESIS
    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && count_q == DepthCnt));
    a_no_pop_empty : assert property (@(posedge clk) disable iff (rst)
        !(pop && count_q == '0));
`endif

endmodule

// File: tb/tb_sram22_port_ctrl.sv
module tb_sram22_port_ctrl;

    localparam int DW    = 32;
    localparam int AW    = 6;
    localparam int WMW   = 1;
    localparam int DEPTH = 3;
    localparam int GRAN  = DW / WMW;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           req_valid = 1'b0;
    logic           req_ready;
    logic           req_we = 1'b0;
    logic [WMW-1:0] req_wmask = '0;
    logic [AW-1:0]  req_addr = '0;
    logic [DW-1:0]  req_wdata = '0;
    logic           rsp_valid;
    logic           rsp_ready = 1'b0;
    logic [DW-1:0]  rsp_rdata;
    logic           sram_we;
    logic [WMW-1:0] sram_wmask;
    logic [AW-1:0]  sram_addr;
    logic [DW-1:0]  sram_din;
    logic [DW-1:0]  sram_dout;

    sram22_port_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .WMASK_WIDTH(WMW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_wmask (req_wmask),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .sram_we   (sram_we),
        .sram_wmask(sram_wmask),
        .sram_addr (sram_addr),
        .sram_din  (sram_din),
        .sram_dout (sram_dout)
    );

    always #5 clk = ~clk;

    // Stand-in for the sram22 macro: synchronous read, masked write.
    logic [DW-1:0] mac_mem [2**AW];
    always @(posedge clk) begin
        if (sram_we) begin
            for (int j = 0; j < WMW; j++) begin
                if (sram_wmask[j]) mac_mem[sram_addr][j*GRAN +: GRAN] <= sram_din[j*GRAN +: GRAN];
            end
        end
        sram_dout <= mac_mem[sram_addr];
    end

    int compared = 0;
    int mismatched = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: every accepted request that yields a beat is queued with
    // the edge after which it becomes visible (accept edge + 1). Credits used =
    // queue size; valid when the head's visibility edge has passed.
    typedef struct {
        logic [DW-1:0] data;
        int            avail;
    } beat_t;

    beat_t         exp_q[$];
    logic [DW-1:0] ref_mem [2**AW];
    int            edge_cnt = 0;
    logic [DW-1:0] beat_log[$];

    initial begin
        for (int i = 0; i < 2**AW; i++) begin
            mac_mem[i] = '0;
            ref_mem[i] = '0;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            bit m_ready, m_valid;
            m_ready = exp_q.size() < DEPTH;
            m_valid = exp_q.size() > 0 && exp_q[0].avail <= edge_cnt;
            if (rsp_valid && rsp_ready) beat_log.push_back(rsp_rdata);
            edge_cnt++;
            if (m_valid && rsp_ready) void'(exp_q.pop_front());
            if (req_valid && m_ready) begin
                if (req_we) begin
                    for (int j = 0; j < WMW; j++) begin
                        if (req_wmask[j]) ref_mem[req_addr][j*GRAN +: GRAN] = req_wdata[j*GRAN +: GRAN];
                    end
`ifdef SRAM22_CTRL_WRITE_ACK_EN
                    exp_q.push_back('{data: '0, avail: edge_cnt + 1});
`endif
                end else begin
                    exp_q.push_back('{data: ref_mem[req_addr], avail: edge_cnt + 1});
                end
            end
        end
    end

    // Compare process: outputs are checked every cycle on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_req_ready", 64'(req_ready), 64'(0));
            chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
            chk("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
            chk("rst_sram_we", 64'(sram_we), 64'(0));
        end else begin
            bit mv, mr;
            mr = exp_q.size() < DEPTH;
            mv = exp_q.size() > 0 && exp_q[0].avail <= edge_cnt;
            chk("req_ready", 64'(req_ready), 64'(mr));
            chk("rsp_valid", 64'(rsp_valid), 64'(mv));
            if (mv) chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_q[0].data));
            chk("sram_we", 64'(sram_we), 64'(req_valid && mr && req_we));
            if (req_valid && mr) chk("sram_addr", 64'(sram_addr), 64'(req_addr));
        end
    end

    // Present one request and hold it until accepted (bounded).
    task automatic send(input logic we, input logic [WMW-1:0] m, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
        int  n = 0;
        bit  done = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_wmask = m;
        req_addr  = a;
        req_wdata = d;
        while (!done) begin
            @(posedge clk);
            if (req_ready) done = 1;
            else if (++n > 100) begin
                chk("send_timeout", 64'(0), 64'(1));
                done = 1;
            end
        end
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_beats(input int n);
        int k = 0;
        while (beat_log.size() < n && k < 200) begin
            @(posedge clk);
            k++;
        end
        #1;
        if (beat_log.size() < n) chk("beat_timeout", 64'(beat_log.size()), 64'(n));
    endtask

    task automatic drain();
        rsp_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
    endtask

    initial begin
        int acc_edge, k, idx, stalls, nb;
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_edge, k, idx, stalls, nb;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Write then read: beat visible in the cycle after accept edge + 1.
        rsp_ready = 1'b1;
        send(1'b1, 1'b1, 6'd5, 32'hDEADBEEF);
        repeat (3) @(posedge clk);
        #1 beat_log.delete();
        send(1'b0, 1'b1, 6'd5, '0);
        acc_edge = edge_cnt;
        k = 0;
        @(negedge clk);
        while (!rsp_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("wr_rd_latency", 64'(edge_cnt - acc_edge), 64'(1));
        chk("wr_rd_data", 64'(rsp_rdata), 64'h0DEADBEEF);
        drain();

        // Streaming reads.
        for (int i = 0; i < 64; i++) send(1'b1, 1'b1, AW'(i), DW'(i) * 32'h01010101);
        drain();
        beat_log.delete();
        stalls = 0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        for (int i = 0; i < 64; i++) begin
            req_addr = AW'(i);
            k = 0;
            @(posedge clk);
            while (!req_ready && k < 50) begin
                stalls++;
                k++;
                @(posedge clk);
            end
            #1;
        end
        req_valid = 1'b0;
        chk("stream_stalls", 64'(stalls), 64'(0));
        wait_beats(64);
        for (int i = 0; i < 64 && i < beat_log.size(); i++)
            chk("stream_beat", 64'(beat_log[i]), 64'(DW'(i) * 32'h01010101));
        drain();

        // Backpressure: only DEPTH reads fit while the consumer stalls.
        beat_log.delete();
        rsp_ready = 1'b0;
        idx = 0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 6'd10;
        repeat (8) begin
            @(posedge clk);
            if (req_valid && req_ready) idx++;
            #1 req_addr = AW'(10 + idx);
        end
        chk("bp_accepted", 64'(idx), 64'(3));
        chk("bp_req_ready", 64'(req_ready), 64'(0));
        rsp_ready = 1'b1;
        k = 0;
        while (idx < 5 && k < 50) begin
            @(posedge clk);
            if (req_ready) idx++;
            k++;
            #1 req_addr = AW'(10 + idx);
        end
        req_valid = 1'b0;
        chk("bp_total", 64'(idx), 64'(5));
        wait_beats(5);
        for (int i = 0; i < 5 && i < beat_log.size(); i++)
            chk("bp_beat", 64'(beat_log[i]), 64'(DW'(10 + i) * 32'h01010101));
        drain();

        // Masked write leaves contents unchanged.
        beat_log.delete();
        send(1'b1, 1'b1, 6'd7, 32'h12345678);
        send(1'b1, 1'b0, 6'd7, 32'hFFFFFFFF);
        send(1'b0, 1'b1, 6'd7, '0);
`ifdef SRAM22_CTRL_WRITE_ACK_EN
        nb = 3;
`else
        nb = 1;
`endif
        wait_beats(nb);
        if (beat_log.size() >= nb) chk("masked_write", 64'(beat_log[nb-1]), 64'h12345678);
        drain();

        // Reset with 2 buffered and 1 pending.
        rsp_ready = 1'b0;
        send(1'b0, 1'b1, 6'd1, '0);
        send(1'b0, 1'b1, 6'd2, '0);
        send(1'b0, 1'b1, 6'd3, '0);
        rst = 1'b1;
        #1;
        chk("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("midrst_rsp_rdata", 64'(rsp_rdata), 64'(0));
        @(negedge clk);
        #1 rst = 1'b0;
        beat_log.delete();
        rsp_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1 chk("midrst_no_beats", 64'(beat_log.size()), 64'(0));
        send(1'b0, 1'b1, 6'd3, '0);
        wait_beats(1);
        if (beat_log.size() >= 1) chk("midrst_reread", 64'(beat_log[0]), 64'h03030303);
        drain();

        // Write ack ordering.
        beat_log.delete();
        send(1'b1, 1'b1, 6'd20, 32'hA5A5A5A5);
        send(1'b0, 1'b1, 6'd20, '0);
`ifdef SRAM22_CTRL_WRITE_ACK_EN
        wait_beats(2);
        if (beat_log.size() >= 2) begin
            chk("wack_first", 64'(beat_log[0]), 64'h0);
            chk("wack_second", 64'(beat_log[1]), 64'hA5A5A5A5);
        end
        nb = 2;
`else
        wait_beats(1);
        if (beat_log.size() >= 1) chk("wack_only", 64'(beat_log[0]), 64'hA5A5A5A5);
        nb = 1;
`endif
        drain();
        chk("wack_count", 64'(beat_log.size()), 64'(nb));

        // Randomized traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk);
            #1;
            req_valid = ($urandom_range(0, 9) < 7);
            req_we    = ($urandom_range(0, 9) < 4);
            req_wmask = WMW'($urandom);
            req_addr  = AW'($urandom);
            req_wdata = $urandom;
            rsp_ready = ($urandom_range(0, 9) < 6);
        end
        req_valid = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
